serial_adder: RTL

Parametrised multi-cycle adder that sums two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a registered carry chain. It is the sequential generalisation of the single-bit full adder: a full-adder slice is reused over WIDTH/DIGIT cycles under a start/busy/done handshake. It serves as the arithmetic datapath element for later lab stages, where area matters more than single-cycle latency.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_slice.sv | 29 ++
 rtl/serial_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Used by serial_adder; the subtract option is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(width/digit), never narrower than one bit.
  function automatic int cnt_width(input int width, input int digit);
    int w;
    w = $clog2(width / digit);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational DIGIT-bit ripple of full adders, reused every cycle by serial_adder.
// ctop is the carry into the top bit, needed for signed overflow detection.
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             ctop
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = c[DIGIT];
  assign ctop = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + ci, DIGIT bits per clock, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b when sub=1 at accept).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nx;
  logic             carry;
  logic             accept;
  logic             last;
  logic [DIGIT-1:0] sdig;
  logic             cdig;
  logic             ctop;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the operand is inverted and the carry forced.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : ci;
`else
  assign b_in = b;
  assign c_in = ci;
`endif

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (areg[DIGIT-1:0]),
    .y    (breg[DIGIT-1:0]),
    .cin  (carry),
    .s    (sdig),
    .cout (cdig),
    .ctop (ctop)
  );

  // Result digits enter at the MSB end so the sum is aligned after N shifts.
  assign psum_nx = WIDTH'({sdig, psum} >> DIGIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      psum  <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      areg  <= a;
      breg  <= b_in;
      carry <= c_in;
      psum  <= '0;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      areg  <= areg >> DIGIT;
      breg  <= breg >> DIGIT;
      carry <= cdig;
      psum  <= psum_nx;
      if (last) begin
        sum <= psum_nx;
        co  <= cdig;
        ovf <= ctop ^ cdig;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
